// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator BCD display path.
// Holds the converter FSM encoding, the BCD digit geometry and a power-of-ten helper.
package calc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int BCD_DIGIT_W = 4;
  localparam int ADD3_THRESH = 5;

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bin_to_bcd_serial_if.sv
// Producer/consumer bundle of the serial binary-to-BCD converter.
// The master side drives din/in_valid/out_ready; the converter is the slave.
interface bin_to_bcd_serial_if
  import calc_pkg::*;
#(
  parameter int IN_WIDTH = 32,
  parameter int DIGITS   = 4
) ();

  logic [IN_WIDTH-1:0]           din;
  logic                          in_valid;
  logic                          in_ready;
  logic [BCD_DIGIT_W*DIGITS-1:0] bcd;
  logic                          neg;
  logic                          ovf;
  logic                          out_valid;
  logic                          out_ready;

  modport master (
    output din, in_valid, out_ready,
    input  in_ready, bcd, neg, ovf, out_valid
  );

  modport slave (
    input  din, in_valid, out_ready,
    output in_ready, bcd, neg, ovf, out_valid
  );

endinterface

// File: rtl/bin_to_bcd_serial_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the next shift.
// Purely combinational.
module bcd_digit_adj
  import calc_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  assign digit_o = (digit_i >= BCD_DIGIT_W'(ADD3_THRESH)) ? digit_i + BCD_DIGIT_W'(3) : digit_i;

endmodule

// File: rtl/bin_to_bcd_serial.sv
// Serial shift-add-3 binary-to-BCD converter, one input bit per clock; result IN_WIDTH cycles after accept.
// Accepts only in IDLE; DONE holds the result until out_ready, outputs change only on SHIFT->DONE.
module bin_to_bcd_serial
  import calc_pkg::*;
#(
  parameter int IN_WIDTH = 32,
  parameter int DIGITS   = 4,
  parameter int SIGNED   = 0
) (
  input logic               clk,
  input logic               reset,
  bin_to_bcd_serial_if.slave io
);

  localparam int BW = BCD_DIGIT_W * DIGITS;
  localparam int CW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;

  state_e              state_q;
  logic [IN_WIDTH-1:0] shreg_q;
  logic [BW-1:0]       work_q;
  logic [BW-1:0]       bcd_q;
  logic [CW-1:0]       cnt_q;
  logic                sign_q;
  logic                ovf_work_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                neg_q;
  logic                ovf_q;

  logic [BW-1:0]       work_adj;
  logic [BW:0]         work_shift;
  logic [BW-1:0]       work_d;
  logic                carry_d;
  logic                is_neg;
  logic [IN_WIDTH-1:0] mag_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (work_q  [g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (work_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // The bit falling off the top digit is a multiple of 10^DIGITS, so it only feeds ovf.
  assign work_shift = {work_adj, shreg_q[IN_WIDTH-1]};
  assign work_d     = work_shift[BW-1:0];
  assign carry_d    = work_shift[BW];

  // Most-negative input negates to itself, which read unsigned is the correct magnitude.
  assign is_neg = (SIGNED != 0) && io.din[IN_WIDTH-1];
  assign mag_d  = is_neg ? -io.din : io.din;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      work_q      <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      ovf_work_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      bcd_q       <= '0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (io.in_valid && in_ready_q) begin
            shreg_q    <= mag_d;
            sign_q     <= is_neg;
            work_q     <= '0;
            ovf_work_q <= 1'b0;
            cnt_q      <= CW'(IN_WIDTH - 1);
            in_ready_q <= 1'b0;
            state_q    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shreg_q    <= shreg_q << 1;
          work_q     <= work_d;
          ovf_work_q <= ovf_work_q | carry_d;
          if (cnt_q == '0) begin
            bcd_q       <= work_d;
            neg_q       <= sign_q;
            ovf_q       <= ovf_work_q | carry_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_DONE: begin
          if (io.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.bcd       = bcd_q;
  assign io.neg       = neg_q;
  assign io.ovf       = ovf_q;

endmodule
